// File: rtl/multiword_addsub_seq.sv
// Wide add/subtract built from one W-bit adder slice reused over WORDS cycles,
// least-significant word first, with a start/busy/done handshake.
module multiword_addsub_seq #(
  parameter int W     = 16,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [W*WORDS-1:0]   a,
  input  logic [W*WORDS-1:0]   b,
  output logic                 busy,
  output logic                 done,
  output logic [W*WORDS-1:0]   s,
  output logic                 co,
  output logic                 ovf
);

  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q [WORDS];
  logic [W-1:0]       a_d [WORDS];
  logic [W-1:0]       b_q [WORDS];
  logic [W-1:0]       b_d [WORDS];
  logic [W-1:0]       s_q [WORDS];
  logic [W-1:0]       s_d [WORDS];
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               co_q, co_d;
  logic               ovf_q, ovf_d;

  logic [W-1:0]       a_word, b_word;
  logic [W:0]         slice_full;
  logic               last_word;

  // Shared adder slice; b_word is already complemented for subtraction.
  assign a_word     = a_q[idx_q];
  assign b_word     = b_q[idx_q];
  assign slice_full = {1'b0, a_word} + {1'b0, b_word} + (W+1)'(carry_q);
  assign last_word  = (idx_q == IDX_W'(WORDS - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < WORDS; i++) begin
            a_d[i] = a[i*W +: W];
            b_d[i] = b[i*W +: W] ^ {W{sub}};
            s_d[i] = '0;
          end
          carry_d = sub;
          idx_d   = '0;
          co_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[idx_q] = slice_full[W-1:0];
        carry_d    = slice_full[W];
        idx_d      = idx_q + IDX_W'(1);
        if (last_word) begin
          idx_d   = '0;
          co_d    = slice_full[W];
          // Carry into the MSB recovered from the MSB sum bit.
          ovf_d   = a_word[W-1] ^ b_word[W-1] ^ slice_full[W-1] ^ slice_full[W];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < WORDS; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        s_q[i] <= '0;
      end
      carry_q <= 1'b0;
      idx_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_s_out
      assign s[gi*W +: W] = s_q[gi];
    end
  endgenerate

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_multiword_addsub_seq.sv
// Bench for multiword_addsub_seq: cycle-level reference model built from plain
// N-bit arithmetic, directed cases with literal results, and randomized traffic.
module tb_multiword_addsub_seq;

  localparam int W     = 16;
  localparam int WORDS = 4;
  localparam int N     = W * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, co, ovf;
  logic [N-1:0] s;

  int n_chk  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  multiword_addsub_seq #(.W(W), .WORDS(WORDS)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .s    (s),
    .co   (co),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: cnt = cycles since acceptance (0 = idle, WORDS+1 = done cycle).
  int           cnt = 0;
  logic [N-1:0] pend_s = '0, exp_s = '0;
  logic         pend_co = 1'b0, pend_ovf = 1'b0, exp_co = 1'b0, exp_ovf = 1'b0;

  always @(posedge clk) begin
    logic [N+1:0] ea, eb, t;
    if (rst) begin
      cnt = 0; exp_s = '0; exp_co = 1'b0; exp_ovf = 1'b0;
    end else if (cnt == 0) begin
      if (start) begin
        ea       = {{2{a[N-1]}}, a};
        eb       = {{2{b[N-1]}}, b};
        t        = sub ? (ea - eb) : (ea + eb);
        pend_s   = sub ? (a - b) : (a + b);
        pend_co  = sub ? (a >= b) : (({1'b0, a} + {1'b0, b}) >> N) != 0;
        pend_ovf = (t[N+1:N-1] != 3'b000) && (t[N+1:N-1] != 3'b111);
        exp_s = '0; exp_co = 1'b0; exp_ovf = 1'b0;
        cnt = 1;
        $display("txn a=%h b=%h sub=%0d -> s=%h co=%0d ovf=%0d", a, b, sub, pend_s, pend_co, pend_ovf);
      end
    end else if (cnt == WORDS + 1) begin
      cnt = 0;
    end else begin
      cnt++;
      if (cnt == WORDS + 1) begin
        exp_s = pend_s; exp_co = pend_co; exp_ovf = pend_ovf;
      end
    end
  end

  function automatic logic [N-1:0] low_words(input logic [N-1:0] v, input int k);
    logic [N-1:0] m;
    m = (k == 0) ? '0 : ({N{1'b1}} >> (N - k * W));
    return v & m;
  endfunction

  // Every cycle: handshake, held/cleared results, and words written so far while running.
  always @(negedge clk) begin
    if (checking) begin
      chk("busy", busy, N'(cnt != 0));
      chk("done", done, N'(cnt == WORDS + 1));
      chk("co", co, N'(exp_co));
      chk("ovf", ovf, N'(exp_ovf));
      if (cnt >= 1 && cnt <= WORDS)
        chk("s_partial", s, low_words(pend_s, cnt - 1));
      else
        chk("s", s, exp_s);
    end
  end

  task automatic op_lit(input string nm, input logic [N-1:0] xa, input logic [N-1:0] xb,
                        input logic xs, input logic [N-1:0] es, input logic eco, input logic eovf);
    int lat;
    @(negedge clk); a = xa; b = xb; sub = xs; start = 1'b1;
    @(negedge clk); start = 1'b0; a = ~xa; b = ~xb;
    lat = 1;
    chk({nm, "_busy_c1"}, N'(busy), N'(1));
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, N'(lat), N'(WORDS + 1));
    chk({nm, "_s"}, s, es);
    chk({nm, "_co"}, N'(co), N'(eco));
    chk({nm, "_ovf"}, N'(ovf), N'(eovf));
    chk({nm, "_model_s"}, exp_s, es);
    chk({nm, "_model_co"}, N'(exp_co), N'(eco));
    chk({nm, "_model_ovf"}, N'(exp_ovf), N'(eovf));
    @(negedge clk);
    chk({nm, "_busy_after"}, N'(busy), N'(0));
    chk({nm, "_s_held"}, s, es);
  endtask

  function automatic logic [N-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return {N{1'b1}};
      1:       return '0;
      2:       return {1'b1, {(N-1){1'b0}}};
      3:       return {1'b0, {(N-1){1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_busy", N'(busy), N'(0));
    chk("rst_done", N'(done), N'(0));
    chk("rst_s", s, '0);
    chk("rst_co", N'(co), N'(0));
    chk("rst_ovf", N'(ovf), N'(0));
    rst = 1'b0;
    checking = 1'b1;

    op_lit("cross", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    op_lit("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
    op_lit("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    op_lit("sub7m5", 64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0);
    op_lit("sub5m7", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    op_lit("sub0mmin", 64'h0, 64'h8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // Handshake: starts during RUN and DONE ignored; start held from cycle 5 accepted in cycle 6.
    @(negedge clk); a = 64'd1; b = 64'd2; sub = 1'b0; start = 1'b1;   // cycle 0
    @(negedge clk); start = 1'b0;                                       // cycle 1
    @(negedge clk); start = 1'b1; a = 64'd100; b = 64'd200;             // cycle 2
    @(negedge clk); start = 1'b0; a = 64'd0; b = 64'd0;                 // cycle 3
    @(negedge clk);                                                     // cycle 4
    @(negedge clk); start = 1'b1; a = 64'd10; b = 64'd20;               // cycle 5
    chk("hs_done1", N'(done), N'(1));
    chk("hs_s1", s, 64'd3);
    @(negedge clk);                                                     // cycle 6
    chk("hs_idle_c6", N'(busy), N'(0));
    repeat (5) @(negedge clk);                                          // cycle 11
    chk("hs_done2", N'(done), N'(1));
    chk("hs_s2", s, 64'd30);
    start = 1'b0;
    @(negedge clk);
    chk("hs_idle_c12", N'(busy), N'(0));

    // Reset in RUN cycle 2 aborts the operation with no done pulse.
    @(negedge clk); a = 64'h1234; b = 64'h1; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", N'(busy), N'(0));
    chk("abort_done", N'(done), N'(0));
    chk("abort_s", s, '0);
    chk("abort_co", N'(co), N'(0));
    chk("abort_ovf", N'(ovf), N'(0));
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", N'(seen), N'(0));
    op_lit("after_rst", 64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0);

    // Randomized traffic, including starts while busy and occasional resets.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      sub   = 1'($urandom_range(0, 1));
      a     = rand_op();
      b     = rand_op();
      rst   = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    repeat (WORDS + 3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multiword_addsub_seq.md
# multiword_addsub_seq

Sequencer that performs WORDS×W-bit add or subtract by time-multiplexing one W-bit adder slice (a, b, ci -> s, co; same behaviour as the team's sixteen-bit ripple adder) over WORDS clock cycles, least-significant word first, with the carry held in a register between words. It sits in front of the combinational adder datapath and lets wide arithmetic reuse a narrow slice at the cost of latency. A start/busy/done handshake makes it usable by a simple FSM master.

## Interface
- W, 16, width of the shared adder slice in bits
- WORDS, 4, number of words per operation (operand width N = W*WORDS); WORDS >= 2
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new operation; accepted only when idle
- sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  N  operand A (unsigned / two's complement), sampled with start
- b  input  N  operand B, sampled with start
- busy  output  1  high whenever not IDLE
- done  output  1  one-cycle pulse: result valid
- s  output  N  result; held from done until next accepted start
- co  output  1  final carry out (subtract: 1 = no borrow)
- ovf  output  1  signed overflow of the N-bit result

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> latch a, latch b XOR {N{sub}} (one's complement on subtract), carry register <= sub, word index <= 0, clear s, go RUN. start=0 -> stay.
- RUN: slice inputs = word[idx] of latched A, latched B', carry register. At edge: s word[idx] <= slice sum, carry register <= slice carry out, idx <= idx+1. After idx = WORDS-1 is processed: co <= slice carry out, ovf <= (carry into slice MSB) XOR (slice carry out), go DONE.
- Carry into slice MSB = A'[N-1] XOR B'[N-1] XOR sum[N-1] of the final word.
- DONE: done=1 for exactly this cycle, go IDLE unconditionally. start in DONE is ignored.
- start while busy is ignored; latched operands unaffected by input changes after acceptance.
- s, co and ovf hold their values in IDLE until the next start is accepted. The accept edge clears s, co and ovf to 0.
- Width rules: idx is ceil(log2(WORDS)) bits; it never wraps within an operation.
- Reset: state IDLE, s=0, co=0, ovf=0, done=0, busy=0, carry=0, idx=0. Reset during RUN or DONE aborts the operation; no done pulse is produced for it.
- rst and start in the same cycle: rst wins.

## Timing
- start accepted at edge E0 (state IDLE, start=1). busy=1 from the cycle after E0.
- RUN occupies WORDS cycles. done=1 in cycle WORDS+1 after acceptance (cycle 5 for WORDS=4), and s/co/ovf are final in that cycle.
- busy falls in cycle WORDS+2. The earliest next accepted start is sampled in that cycle, giving a throughput of one operation per WORDS+2 cycles.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
All cases use W=16, WORDS=4.
- Cross-word carry: a=0x0000_0000_0000_FFFF, b=1, sub=0 -> s=0x0000_0000_0001_0000, co=0, ovf=0, done pulse in cycle 5 only, busy high in cycles 1-5.
- Full wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> s=0, co=1, ovf=0.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> s=0x8000_0000_0000_0000, co=0, ovf=1.
- Subtract:
  - a=7, b=5, sub=1 -> s=2, co=1, ovf=0.
  - a=5, b=7, sub=1 -> s=0xFFFF_FFFF_FFFF_FFFE, co=0, ovf=0.
- Handshake:
  - Operation 1 is 1+2. Pulse start with new operands in cycles 2 and 5; both are ignored, and the result is s=3.
  - Operation 2 is 10+20, with start held high continuously after operation 1's done. It is accepted in cycle 6, and its done pulse appears 5 cycles later with s=30.
- Reset mid-op: start 0x1234+0x1, assert rst in RUN cycle 2 -> next cycle busy=0, done=0, s=0, co=0, ovf=0, and no done pulse follows. A subsequent start of 3+4 completes with s=7.
